pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter sequencer with multi-cycle call/return handshakes to an external return stack.
// Tracks return-stack depth locally and flags over/underflow without touching the stack.
module pc_sequencer #(
  parameter int                 WIDTH    = 18,
  parameter int                 DEPTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             call,
  input  logic             ret,
  input  logic             jump,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] stack_rdata,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] stack_wdata,
  output logic             stack_push,
  output logic             stack_pop,
  output logic             busy,
  output logic             overflow,
  output logic             underflow
);

  localparam int DW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    RUN,
    CALL_SETUP,
    CALL_PUSH,
    RET_POP,
    RET_WAIT,
    RET_LOAD
  } state_t;

  state_t           state;
  logic [DW-1:0]    depth;
  logic [WIDTH-1:0] call_target;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc = pc + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      depth       <= '0;
      call_target <= '0;
      stack_wdata <= '0;
      stack_push  <= 1'b0;
      stack_pop   <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            if (call) begin
              if (depth < DW'(DEPTH)) begin
                // Target is captured now: inputs are ignored while the push completes.
                stack_wdata <= pc_inc;
                call_target <= target;
                busy        <= 1'b1;
                state       <= CALL_SETUP;
              end else begin
                overflow <= 1'b1;
                pc       <= target;
              end
            end else if (ret) begin
              if (depth != '0) begin
                stack_pop <= 1'b1;
                busy      <= 1'b1;
                state     <= RET_POP;
              end else begin
                underflow <= 1'b1;
                pc        <= pc_inc;
              end
            end else if (jump || branch_taken) begin
              pc <= target;
            end else begin
              pc <= pc_inc;
            end
          end
        end
        CALL_SETUP: begin
          stack_push <= 1'b1;
          state      <= CALL_PUSH;
        end
        CALL_PUSH: begin
          stack_push <= 1'b0;
          pc         <= call_target;
          depth      <= depth + DW'(1);
          busy       <= 1'b0;
          state      <= RUN;
        end
        RET_POP: begin
          stack_pop <= 1'b0;
          state     <= RET_WAIT;
        end
        RET_WAIT: begin
          state <= RET_LOAD;
        end
        RET_LOAD: begin
          // The stack has had a full idle cycle after the pop to present the address.
          pc    <= stack_rdata;
          depth <= depth - DW'(1);
          busy  <= 1'b0;
          state <= RUN;
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a timeline-of-expected-outputs model plus directed literal checks,
// followed by a randomized run with occasional resets and stalls.
module tb_pc_sequencer;
  localparam int W = 18;
  localparam int D = 32;
  localparam logic [W-1:0] RPC = '0;

  logic         clk = 1'b0;
  logic         reset, en, call, ret, jump, branch_taken;
  logic [W-1:0] target, stack_rdata;
  logic [W-1:0] pc, stack_wdata;
  logic         stack_push, stack_pop, busy, overflow, underflow;

  pc_sequencer #(.WIDTH(W), .DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .en(en), .call(call), .ret(ret), .jump(jump),
    .branch_taken(branch_taken), .target(target), .stack_rdata(stack_rdata),
    .pc(pc), .stack_wdata(stack_wdata), .stack_push(stack_push), .stack_pop(stack_pop),
    .busy(busy), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Expected visible outputs after an edge; an accepted call/ret queues its future snapshots.
  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] wdata;
    logic         push;
    logic         pop;
    logic         busy;
  } snap_t;

  snap_t        plan[$];
  snap_t        exp_o = '0;
  int           m_depth = 0;
  logic         m_ovf = 1'b0, m_unf = 1'b0;
  logic [W-1:0] stk[$];
  logic [W-1:0] ret_val = '0;
  int           tests = 0, fails = 0, push_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_edge();
    snap_t        s;
    logic [W-1:0] nxt;
    nxt = exp_o.pc + W'(1);
    s   = exp_o;
    if (reset) begin
      plan.delete();
      stk.delete();
      exp_o    = '0;
      exp_o.pc = RPC;
      m_depth  = 0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
    end else if (plan.size() > 0) begin
      exp_o = plan.pop_front();
    end else if (en) begin
      if (call) begin
        if (m_depth < D) begin
          s.wdata = nxt; s.busy = 1'b1; exp_o = s;
          s.push = 1'b1; plan.push_back(s);
          s.push = 1'b0; s.busy = 1'b0; s.pc = target; plan.push_back(s);
          m_depth++;
          stk.push_back(nxt);
        end else begin
          m_ovf    = 1'b1;
          exp_o.pc = target;
        end
      end else if (ret) begin
        if (m_depth > 0) begin
          ret_val = stk.pop_back();
          s.pop = 1'b1; s.busy = 1'b1; exp_o = s;
          s.pop = 1'b0; plan.push_back(s); plan.push_back(s);
          s.busy = 1'b0; s.pc = ret_val; plan.push_back(s);
          m_depth--;
        end else begin
          m_unf    = 1'b1;
          exp_o.pc = nxt;
        end
      end else if (jump || branch_taken) begin
        exp_o.pc = target;
      end else begin
        exp_o.pc = nxt;
      end
    end
  endtask

  // One clock: present the stack's top, advance the model at the edge, compare after it.
  task automatic cyc();
    stack_rdata = (plan.size() > 0) ? ret_val : W'($urandom);
    @(posedge clk);
    model_edge();
    #1;
    if (stack_push) push_cnt++;
    check("pc", pc, exp_o.pc);
    check("stack_wdata", stack_wdata, exp_o.wdata);
    check("stack_push", stack_push, exp_o.push);
    check("stack_pop", stack_pop, exp_o.pop);
    check("busy", busy, exp_o.busy);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_unf);
    tests++;
    if (stack_push && stack_pop) begin
      fails++;
      $display("FAIL push_pop_overlap: got both high expected exclusive at %0t", $time);
    end
  endtask

  task automatic setreq(input logic c, input logic r, input logic j, input logic b, input logic [W-1:0] t);
    reset = 1'b0; en = 1'b1; call = c; ret = r; jump = j; branch_taken = b; target = t;
  endtask

  // Random requests that must be ignored while the sequencer is busy.
  task automatic junk();
    reset = 1'b0; en = 1'($urandom); call = 1'($urandom); ret = 1'($urandom);
    jump = 1'($urandom); branch_taken = 1'($urandom); target = W'($urandom);
  endtask

  task automatic do_reset();
    setreq(0, 0, 0, 0, '0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    setreq(0, 0, 0, 0, '0);
    stack_rdata = '0;
    @(negedge clk);

    // Reset and sequential run.
    do_reset();
    check("reset_pc", pc, 18'h0);
    check("reset_busy", busy, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("seq_pc", pc, W'(i));
    end

    // Call from 0x10 to 0x100.
    setreq(0, 0, 1, 0, 18'h10); cyc();
    check("jump_pc", pc, 18'h10);
    setreq(1, 0, 0, 0, 18'h100); cyc();
    check("call_wdata", stack_wdata, 18'h11);
    check("call_push_e1", stack_push, 1'b0);
    check("call_busy_e1", busy, 1'b1);
    junk(); cyc();
    check("call_push_e2", stack_push, 1'b1);
    check("call_wdata_e2", stack_wdata, 18'h11);
    junk(); cyc();
    check("call_push_e3", stack_push, 1'b0);
    check("call_pc", pc, 18'h100);
    check("call_busy_e3", busy, 1'b0);

    // Return: the bench's stack supplies 0x11.
    setreq(0, 1, 0, 0, 18'h3333); cyc();
    check("ret_pop_e1", stack_pop, 1'b1);
    junk(); cyc();
    check("ret_pop_e2", stack_pop, 1'b0);
    junk(); cyc();
    check("ret_busy_e3", busy, 1'b1);
    junk(); cyc();
    check("ret_pc", pc, 18'h11);
    check("ret_busy_e4", busy, 1'b0);

    // Return at depth 0 from pc=5.
    setreq(0, 0, 0, 1, 18'h5); cyc();
    setreq(0, 1, 0, 0, 18'h0); cyc();
    check("unf_pc", pc, 18'h6);
    check("unf_flag", underflow, 1'b1);
    check("unf_pop", stack_pop, 1'b0);

    // call+ret+jump together: call wins.
    setreq(1, 1, 1, 0, 18'h200); cyc();
    check("prio_wdata", stack_wdata, 18'h7);
    junk(); cyc();
    junk(); cyc();
    check("prio_pc", pc, 18'h200);
    setreq(0, 1, 0, 0, '0); cyc();
    junk(); cyc(); junk(); cyc(); junk(); cyc();
    check("prio_ret_pc", pc, 18'h7);

    // Fill the stack, then one call too many.
    do_reset();
    push_cnt = 0;
    for (int i = 0; i < D; i++) begin
      setreq(1, 0, 0, 0, W'($urandom)); cyc();
      junk(); cyc();
      junk(); cyc();
    end
    setreq(1, 0, 0, 0, 18'h3ABC); cyc();
    check("ovf_pushes", W'(push_cnt), W'(32));
    check("ovf_flag", overflow, 1'b1);
    check("ovf_pc", pc, 18'h3ABC);
    check("ovf_push", stack_push, 1'b0);
    check("ovf_busy", busy, 1'b0);
    setreq(0, 0, 0, 0, '0); cyc();
    check("ovf_sticky", overflow, 1'b1);

    // Reset while the push pulse is high.
    do_reset();
    setreq(1, 0, 0, 0, 18'h1234); cyc();
    junk(); cyc();
    check("abort_push_hi", stack_push, 1'b1);
    setreq(0, 0, 0, 0, '0); reset = 1'b1; cyc();
    check("abort_push", stack_push, 1'b0);
    check("abort_pc", pc, 18'h0);
    check("abort_busy", busy, 1'b0);
    setreq(0, 0, 0, 0, '0); cyc();
    check("abort_next_pc", pc, 18'h1);

    // Wraparound of pc and of the return address.
    setreq(0, 0, 1, 0, 18'h3FFFF); cyc();
    setreq(0, 0, 0, 0, '0); cyc();
    check("wrap_pc", pc, 18'h0);
    setreq(0, 0, 1, 0, 18'h3FFFF); cyc();
    setreq(1, 0, 0, 0, 18'h42); cyc();
    check("wrap_wdata", stack_wdata, 18'h0);
    junk(); cyc(); junk(); cyc();

    // Randomized traffic with stalls and rare resets.
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      en           = ($urandom_range(0, 9) != 0);
      call         = ($urandom_range(0, 4) == 0);
      ret          = ($urandom_range(0, 5) == 0);
      jump         = ($urandom_range(0, 9) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      target       = W'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
